// File: rtl/sift_pkg.sv
// Shared constants and types for the 3x3 blur engine: BRAM timing,
// kernel weights, normalisation shift and the controller state encoding.
package sift_pkg;

  // Cycles from issuing a source read address to data on ext_pixel_in.
  localparam int BRAM_READ_LATENCY = 2;

  // Kernel sums to 16, so the normalisation is a right shift by 4.
  localparam int KERNEL_SHIFT = 4;
  localparam int KERNEL_TAPS  = 9;

  // Raster-ordered weights, tap 0 in the low 3 bits:
  // [1 2 1; 2 4 2; 1 2 1]
  localparam logic [26:0] KERNEL_WEIGHTS = {
    3'd1, 3'd2, 3'd1,
    3'd2, 3'd4, 3'd2,
    3'd1, 3'd2, 3'd1
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } blur_state_t;

  // Weight lookup for a tap index; out-of-range indices weigh nothing.
  function automatic logic [2:0] kernel_weight(input logic [3:0] tap);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      if (tap == 4'(i)) w = KERNEL_WEIGHTS[i*3 +: 3];
    end
    return w;
  endfunction

endpackage

// File: rtl/blur_tap_gen.sv
// Maps the current output pixel and a tap index to the source address of
// that neighbour (edges replicated by clamping) and its kernel weight.
module blur_tap_gen
  import sift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int XW     = 5,
  parameter int YW     = 5,
  parameter int ADDR_W = 10
) (
  input  logic [XW-1:0]     i_x,
  input  logic [YW-1:0]     i_y,
  input  logic [3:0]        i_tap,
  output logic [ADDR_W-1:0] o_addr,
  output logic [2:0]        o_weight
);

  logic [1:0]    w_row;
  logic [1:0]    w_col;
  logic [XW-1:0] w_cx;
  logic [YW-1:0] w_cy;

  // Split the raster tap index into kernel row/column (0 = -1, 2 = +1).
  always_comb begin
    w_row = 2'd1;
    w_col = 2'd1;
    case (i_tap)
      4'd0: begin w_row = 2'd0; w_col = 2'd0; end
      4'd1: begin w_row = 2'd0; w_col = 2'd1; end
      4'd2: begin w_row = 2'd0; w_col = 2'd2; end
      4'd3: begin w_row = 2'd1; w_col = 2'd0; end
      4'd4: begin w_row = 2'd1; w_col = 2'd1; end
      4'd5: begin w_row = 2'd1; w_col = 2'd2; end
      4'd6: begin w_row = 2'd2; w_col = 2'd0; end
      4'd7: begin w_row = 2'd2; w_col = 2'd1; end
      4'd8: begin w_row = 2'd2; w_col = 2'd2; end
      default: begin w_row = 2'd1; w_col = 2'd1; end
    endcase
  end

  // Neighbour coordinates, clamped to the image so edges replicate.
  always_comb begin
    w_cx = i_x;
    w_cy = i_y;
    if (w_col == 2'd0 && i_x != '0) w_cx = i_x - XW'(1);
    if (w_col == 2'd2 && i_x != XW'(WIDTH - 1)) w_cx = i_x + XW'(1);
    if (w_row == 2'd0 && i_y != '0) w_cy = i_y - YW'(1);
    if (w_row == 2'd2 && i_y != YW'(HEIGHT - 1)) w_cy = i_y + YW'(1);
  end

  assign o_addr   = ADDR_W'(w_cy) * ADDR_W'(WIDTH) + ADDR_W'(w_cx);
  assign o_weight = kernel_weight(i_tap);

endmodule

// File: rtl/image_blur_3x3.sv
// 3x3 Gaussian blur engine. For every output pixel it reads the nine
// neighbours from a source BRAM, accumulates them with the kernel weights
// as the data returns, and writes the rounded result to a destination BRAM.
// One output pixel every 12 cycles: 9 reads, 2 drain, 1 write.
module image_blur_3x3
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 32
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]  ext_read_addr,
  output logic                             ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]             ext_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]  ext_write_addr,
  output logic                             ext_write_valid,
  output logic [BIT_DEPTH-1:0]             ext_pixel_out,
  output logic                             busy_out,
  output logic                             blur_done
);

  localparam int ADDR_W = $clog2(WIDTH * HEIGHT);
  localparam int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int ACC_W  = BIT_DEPTH + 4;
  localparam int LAT    = BRAM_READ_LATENCY;

  blur_state_t       r_state;
  blur_state_t       w_state_next;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [3:0]        r_tap;        // tap index in READ, drain counter in DRAIN
  logic [ACC_W-1:0]  r_acc;
  logic              r_busy;
  logic              r_blur_done;
  logic [LAT-1:0]    r_vld_pipe;   // tracks which cycles carry tap data
  logic [2:0]        r_wt_pipe [LAT];

  logic [ADDR_W-1:0] w_tap_addr;
  logic [2:0]        w_tap_weight;
  logic              w_read_valid;
  logic              w_write_valid;
  logic              w_last_tap;
  logic              w_last_drain;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_start_ok;

  blur_tap_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW),
    .ADDR_W (ADDR_W)
  ) u_tap_gen (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_tap    (r_tap),
    .o_addr   (w_tap_addr),
    .o_weight (w_tap_weight)
  );

  assign w_read_valid  = (r_state == ST_READ);
  assign w_write_valid = (r_state == ST_WRITE);
  assign w_last_tap    = (r_tap == 4'(KERNEL_TAPS - 1));
  assign w_last_drain  = (r_tap == 4'(LAT - 1));
  assign w_last_col    = (r_x == XW'(WIDTH - 1));
  assign w_last_row    = (r_y == YW'(HEIGHT - 1));
  // A start coinciding with the completion pulse is not a new request.
  assign w_start_ok    = start_in && !r_blur_done;

  // Next-state logic for the per-pixel read/drain/write sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_next = ST_READ;
      ST_READ:  if (w_last_tap) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_last_drain) w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = (w_last_col && w_last_row) ? ST_DONE : ST_READ;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register plus pixel/tap counters and the busy/done flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_tap       <= '0;
      r_busy      <= 1'b0;
      r_blur_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_blur_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_x    <= '0;
            r_y    <= '0;
            r_tap  <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_READ:  r_tap <= w_last_tap ? 4'd0 : r_tap + 4'd1;
        ST_DRAIN: r_tap <= w_last_drain ? 4'd0 : r_tap + 4'd1;
        ST_WRITE: begin
          if (w_last_col) begin
            r_x <= '0;
            if (!w_last_row) r_y <= r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        ST_DONE:  r_busy <= 1'b0;
        default:  r_busy <= 1'b0;
      endcase
    end
  end

  // First stage of the tap tracker: capture the issued tap's weight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vld_pipe[0] <= 1'b0;
      r_wt_pipe[0]  <= '0;
    end else begin
      r_vld_pipe[0] <= w_read_valid;
      r_wt_pipe[0]  <= w_tap_weight;
    end
  end

  // Remaining tracker stages, so the weight lines up with returning data.
  genvar gi;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_tap_delay
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_vld_pipe[gi] <= 1'b0;
          r_wt_pipe[gi]  <= '0;
        end else begin
          r_vld_pipe[gi] <= r_vld_pipe[gi-1];
          r_wt_pipe[gi]  <= r_wt_pipe[gi-1];
        end
      end
    end
  endgenerate

  // Weighted accumulation of returning pixels; cleared once the result is written.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_acc <= '0;
    end else if (w_write_valid) begin
      r_acc <= '0;
    end else if (r_vld_pipe[LAT-1]) begin
      r_acc <= r_acc + ACC_W'(ext_pixel_in) * ACC_W'(r_wt_pipe[LAT-1]);
    end
  end

  assign ext_read_addr_valid = w_read_valid;
  assign ext_read_addr       = w_read_valid ? w_tap_addr : '0;
  assign ext_write_valid     = w_write_valid;
  assign ext_write_addr      = w_write_valid ?
                               (ADDR_W'(r_y) * ADDR_W'(WIDTH) + ADDR_W'(r_x)) : '0;
  // Round to nearest: add half of the divisor, then shift.
  assign ext_pixel_out       = w_write_valid ?
                               BIT_DEPTH'((r_acc + ACC_W'(1 << (KERNEL_SHIFT - 1))) >> KERNEL_SHIFT) : '0;
  assign busy_out            = r_busy;
  assign blur_done           = r_blur_done;

endmodule
